// File: rtl/ibex_pkg.sv
// Shared Ibex definitions used by the CHERI memory-access guard.
// Holds the capability field layout, the permission bit indices and the
// exception-vector bit order, plus the response-tracking entry format.
package ibex_pkg;

  localparam int unsigned CheriCapBits       = 91;
  localparam int unsigned CapPermsWidth      = 12;
  localparam int unsigned CheriExcWidth      = 6;

  localparam int unsigned PermitExecuteIndex = 1;
  localparam int unsigned PermitLoadIndex    = 2;
  localparam int unsigned PermitStoreIndex   = 3;

  // Bit positions inside the CHERI exception vector.
  typedef enum logic [2:0] {
    TAG_VIOLATION            = 3'd0,
    SEAL_VIOLATION           = 3'd1,
    PERMIT_EXECUTE_VIOLATION = 3'd2,
    PERMIT_LOAD_VIOLATION    = 3'd3,
    PERMIT_STORE_VIOLATION   = 3'd4,
    LENGTH_VIOLATION         = 3'd5
  } cheri_exc_idx_e;

  // Field layout of the authorising capability as seen by the decoders.
  typedef struct packed {
    logic                     tag;
    logic [CapPermsWidth-1:0] perms;
    logic [6:0]               kind;
    logic [5:0]               rsvd;
    logic [32:0]              top;
    logic [31:0]              base;
  } cap_fields_t;

  // One tracked request: locally faulted or not, its exceptions, upper-half flag.
  typedef struct packed {
    logic                     fault;
    logic [CheriExcWidth-1:0] exc;
    logic                     upper;
  } resp_entry_t;

endpackage

// File: rtl/ibex_cheri_resp_fifo.sv
// In-order response-tracking FIFO with wrap-at-depth pointers (any depth >= 1).
// Latency: written entry is visible at the head one cycle after the push.
// Backpressure: a push while full is taken only if a pop happens in the same cycle.
module ibex_cheri_resp_fifo #(
  parameter  int unsigned Depth    = 2,
  parameter  int unsigned Width    = 8,
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic [Width-1:0]    wdata_i,
  input  logic                pop_i,
  output logic [Width-1:0]    rdata_o,
  output logic                empty_o,
  output logic                full_o,
  output logic [CntWidth-1:0] count_o
);

  localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] count_q;
  logic                do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DepthCnt);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage needs no reset: only slots between the pointers are ever consumed.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap explicitly at Depth-1; count moves only when push and pop differ.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      if (do_push != do_pop) begin
        count_q <= do_push ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/module_wrap64_getBase.sv
// Capability decode: lower bound.
// Combinational, zero latency.
// No flow control.
module module_wrap64_getBase
  import ibex_pkg::*;
(
  input  logic [CheriCapBits-1:0] wrap64_getBase_cap,
  output logic [31:0]             wrap64_getBase
);

  cap_fields_t cap;
  logic        unused_cap;

  assign cap            = cap_fields_t'(wrap64_getBase_cap);
  assign wrap64_getBase = cap.base;
  assign unused_cap     = ^cap;

endmodule

// File: rtl/module_wrap64_getKind.sv
// Capability decode: kind / object-type field.
// Combinational, zero latency.
// No flow control.
module module_wrap64_getKind
  import ibex_pkg::*;
(
  input  logic [CheriCapBits-1:0] wrap64_getKind_cap,
  output logic [6:0]              wrap64_getKind
);

  cap_fields_t cap;
  logic        unused_cap;

  assign cap            = cap_fields_t'(wrap64_getKind_cap);
  assign wrap64_getKind = cap.kind;
  assign unused_cap     = ^cap;

endmodule

// File: rtl/module_wrap64_getPerms.sv
// Capability decode: permission bits.
// Combinational, zero latency.
// No flow control.
module module_wrap64_getPerms
  import ibex_pkg::*;
(
  input  logic [CheriCapBits-1:0]  wrap64_getPerms_cap,
  output logic [CapPermsWidth-1:0] wrap64_getPerms
);

  cap_fields_t cap;
  logic        unused_cap;

  assign cap             = cap_fields_t'(wrap64_getPerms_cap);
  assign wrap64_getPerms = cap.perms;
  assign unused_cap      = ^cap;

endmodule

// File: rtl/module_wrap64_getTop.sv
// Capability decode: 33-bit exclusive upper bound.
// Combinational, zero latency.
// No flow control.
module module_wrap64_getTop
  import ibex_pkg::*;
(
  input  logic [CheriCapBits-1:0] wrap64_getTop_cap,
  output logic [32:0]             wrap64_getTop
);

  cap_fields_t cap;
  logic        unused_cap;

  assign cap           = cap_fields_t'(wrap64_getTop_cap);
  assign wrap64_getTop = cap.top;
  assign unused_cap    = ^cap;

endmodule

// File: rtl/module_wrap64_isValidCap.sv
// Capability decode: tag bit.
// Combinational, zero latency.
// No flow control.
module module_wrap64_isValidCap
  import ibex_pkg::*;
(
  input  logic [CheriCapBits-1:0] wrap64_isValidCap_cap,
  output logic                    wrap64_isValidCap
);

  cap_fields_t cap;
  logic        unused_cap;

  assign cap               = cap_fields_t'(wrap64_isValidCap_cap);
  assign wrap64_isValidCap = cap.tag;
  assign unused_cap        = ^cap;

endmodule

// File: rtl/ibex_cheri_mem_guard.sv
// CHERI capability guard between an Ibex requester and its bus port; faulting requests never reach the bus.
// Latency: request path combinational; bus responses pass through combinationally, local faults answer at t+1.
// Backpressure: no grant while MaxOutstanding entries are tracked; a faulting request waits for an empty FIFO.
module ibex_cheri_mem_guard
  import ibex_pkg::*;
#(
  parameter bit          DataMem        = 1'b1,
  parameter int unsigned CheriCapWidth  = 91,
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          StableOut      = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [CheriCapWidth-1:0] auth_cap_i,
  input  logic                     req_i,
  output logic                     gnt_o,
  input  logic [31:0]              addr_i,
  input  logic                     we_i,
  input  logic [1:0]               type_i,
  input  logic [3:0]               be_i,
  output logic                     rvalid_o,
  output logic                     err_o,
  output logic [CheriExcWidth-1:0] cheri_exc_o,
  output logic                     instr_upper_exc_o,
  output logic                     req_o,
  input  logic                     gnt_i,
  output logic                     we_o,
  input  logic                     rvalid_i,
  input  logic                     err_i
);

  localparam int unsigned EntryWidth = $bits(resp_entry_t);
  localparam int unsigned CntWidth   = $clog2(MaxOutstanding + 1);

  logic                     cap_valid;
  logic [6:0]               cap_kind;
  logic [31:0]              cap_base;
  logic [32:0]              cap_top;
  logic [CapPermsWidth-1:0] cap_perms;

  module_wrap64_isValidCap u_is_valid (
    .wrap64_isValidCap_cap (auth_cap_i),
    .wrap64_isValidCap     (cap_valid)
  );
  module_wrap64_getKind u_get_kind (
    .wrap64_getKind_cap (auth_cap_i),
    .wrap64_getKind     (cap_kind)
  );
  module_wrap64_getBase u_get_base (
    .wrap64_getBase_cap (auth_cap_i),
    .wrap64_getBase     (cap_base)
  );
  module_wrap64_getTop u_get_top (
    .wrap64_getTop_cap (auth_cap_i),
    .wrap64_getTop     (cap_top)
  );
  module_wrap64_getPerms u_get_perms (
    .wrap64_getPerms_cap (auth_cap_i),
    .wrap64_getPerms     (cap_perms)
  );

  logic [1:0]               be_idx;
  logic [31:0]              start_addr;
  logic [32:0]              acc_size;
  logic [32:0]              end_addr;
  logic [CheriExcWidth-1:0] exc;
  logic                     upper_exc;
  logic                     fault;

  // Bounds, permission, tag and seal checks for the request in flight this cycle.
  always_comb begin
    be_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (be_i[i]) be_idx = 2'(i);
    end
    start_addr = {addr_i[31:2], 2'b00};
    acc_size   = 33'd2;
    if (DataMem) begin
      start_addr = {addr_i[31:2], be_idx};
      case (type_i)
        2'b00:   acc_size = 33'd4;
        2'b01:   acc_size = 33'd2;
        2'b10:   acc_size = 33'd1;
        default: acc_size = 33'd8;
      endcase
    end
    // 33-bit end address so a region reaching 2^32 compares correctly.
    end_addr = {1'b0, start_addr} + acc_size;

    exc                           = '0;
    exc[TAG_VIOLATION]            = ~cap_valid;
    exc[SEAL_VIOLATION]           = (cap_kind[6:4] != 3'b000);
    exc[PERMIT_LOAD_VIOLATION]    = ~we_i & ~cap_perms[PermitLoadIndex];
    exc[PERMIT_STORE_VIOLATION]   = we_i & ~cap_perms[PermitStoreIndex];
    exc[PERMIT_EXECUTE_VIOLATION] = ~DataMem & ~cap_perms[PermitExecuteIndex];
    exc[LENGTH_VIOLATION]         = (start_addr < cap_base) | (end_addr > cap_top);

    // Upper half of a fetched word lies out of bounds; reported, but not a fault.
    upper_exc = ~DataMem & ({1'b0, addr_i[31:2], 2'b11} >= cap_top);
    fault     = |exc;
  end

  logic                  fifo_empty, fifo_full, push, resp_vld;
  logic [CntWidth-1:0]   fifo_count;
  logic [EntryWidth-1:0] fifo_rdata;
  resp_entry_t           push_entry, head;

  assign req_o = req_i & ~fault & ~fifo_full;
  // A local fault is only answered once every older bus transaction has returned,
  // which keeps responses in order and stops a synthetic response colliding with rvalid_i.
  assign gnt_o = fault ? (req_i & fifo_empty) : (gnt_i & ~fifo_full);
  assign we_o  = we_i & ~fault;
  assign push  = req_i & gnt_o;

  assign push_entry = '{fault: fault, exc: exc, upper: upper_exc};
  assign head       = resp_entry_t'(fifo_rdata);

  // Faulted heads retire on their own; others wait for the bus. rvalid_i with a faulted head is dropped.
  assign resp_vld = ~fifo_empty & (head.fault | rvalid_i);

  ibex_cheri_resp_fifo #(
    .Depth (MaxOutstanding),
    .Width (EntryWidth)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (resp_vld),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  logic [CheriExcWidth-1:0] resp_exc;
  logic                     resp_upper;

  assign rvalid_o   = resp_vld;
  assign err_o      = resp_vld & (head.fault | err_i);
  assign resp_exc   = head.fault ? head.exc : '0;
  assign resp_upper = head.upper;

  if (StableOut) begin : g_hold
    logic [CheriExcWidth-1:0] exc_q;
    logic                     upper_q;

    // Keep the last response's exception state visible between responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        exc_q   <= '0;
        upper_q <= 1'b0;
      end else if (resp_vld) begin
        exc_q   <= resp_exc;
        upper_q <= resp_upper;
      end
    end

    assign cheri_exc_o       = resp_vld ? resp_exc : exc_q;
    assign instr_upper_exc_o = resp_vld ? resp_upper : upper_q;
  end else begin : g_pulse
    assign cheri_exc_o       = resp_vld ? resp_exc : '0;
    assign instr_upper_exc_o = resp_vld & resp_upper;
  end

  logic unused_sigs;
  assign unused_sigs = ^{addr_i[1:0], cap_kind[3:0], cap_perms, be_i, type_i, fifo_count};

  // A bus response is only legal for an outstanding, non-faulted head entry.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   rvalid_i |-> (!fifo_empty && !head.fault));

endmodule

// File: tb/tb_ibex_cheri_mem_guard.sv
// Directed bench for the CHERI memory guard: one data-port and one instruction-port instance.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Every expected value below is hand-derived from the capability bounds and permissions.
module tb_ibex_cheri_mem_guard;
  import ibex_pkg::*;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rst_ni;

  int n_pass;
  int n_total;

  // Data port instance signals.
  logic [90:0] d_cap;
  logic        d_req, d_gnt_o, d_we, d_rvalid_o, d_err_o, d_upper_o;
  logic [31:0] d_addr;
  logic [1:0]  d_type;
  logic [3:0]  d_be;
  logic [CheriExcWidth-1:0] d_exc_o;
  logic        d_req_o, d_gnt_i, d_we_o, d_rvalid_i, d_err_i;

  // Instruction port instance signals.
  logic [90:0] i_cap;
  logic        i_req, i_gnt_o, i_rvalid_o, i_err_o, i_upper_o;
  logic [31:0] i_addr;
  logic [CheriExcWidth-1:0] i_exc_o;
  logic        i_req_o, i_gnt_i, i_we_o, i_rvalid_i, i_err_i;

  ibex_cheri_mem_guard #(
    .DataMem(1'b1), .CheriCapWidth(91), .MaxOutstanding(2), .StableOut(1'b1)
  ) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .auth_cap_i(d_cap), .req_i(d_req), .gnt_o(d_gnt_o),
    .addr_i(d_addr), .we_i(d_we), .type_i(d_type), .be_i(d_be), .rvalid_o(d_rvalid_o),
    .err_o(d_err_o), .cheri_exc_o(d_exc_o), .instr_upper_exc_o(d_upper_o), .req_o(d_req_o),
    .gnt_i(d_gnt_i), .we_o(d_we_o), .rvalid_i(d_rvalid_i), .err_i(d_err_i)
  );

  ibex_cheri_mem_guard #(
    .DataMem(1'b0), .CheriCapWidth(91), .MaxOutstanding(2), .StableOut(1'b1)
  ) u_ifetch (
    .clk_i(clk_i), .rst_ni(rst_ni), .auth_cap_i(i_cap), .req_i(i_req), .gnt_o(i_gnt_o),
    .addr_i(i_addr), .we_i(1'b0), .type_i(2'b00), .be_i(4'hF), .rvalid_o(i_rvalid_o),
    .err_o(i_err_o), .cheri_exc_o(i_exc_o), .instr_upper_exc_o(i_upper_o), .req_o(i_req_o),
    .gnt_i(i_gnt_i), .we_o(i_we_o), .rvalid_i(i_rvalid_i), .err_i(i_err_i)
  );

  function automatic logic [90:0] mk_cap(input logic tag, input logic [11:0] perms,
                                         input logic [6:0] kind, input logic [31:0] base,
                                         input logic [32:0] top);
    cap_fields_t c;
    c = '{tag: tag, perms: perms, kind: kind, rsvd: 6'd0, top: top, base: base};
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic req, input logic [90:0] cap, input logic [31:0] addr,
                       input logic we, input logic [1:0] typ, input logic [3:0] be);
    d_req  = req;
    d_cap  = cap;
    d_addr = addr;
    d_we   = we;
    d_type = typ;
    d_be   = be;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [90:0] good, bad, nostore, i_good, i_noexec;
    n_pass  = 0;
    n_total = 0;
    good     = mk_cap(1'b1, 12'hFFF, 7'h00, 32'h1000, 33'h2000);
    bad      = mk_cap(1'b0, 12'hFFB, 7'h10, 32'h1000, 33'h2000);
    nostore  = mk_cap(1'b1, 12'hFF7, 7'h00, 32'h1000, 33'h2000);
    i_good   = mk_cap(1'b1, 12'hFFF, 7'h00, 32'h1000, 33'h1002);
    i_noexec = mk_cap(1'b1, 12'hFFD, 7'h00, 32'h1000, 33'h2000);

    rst_ni = 1'b0;
    drive(1'b0, '0, 32'h0, 1'b0, 2'b00, 4'h0);
    d_gnt_i = 1'b0; d_rvalid_i = 1'b0; d_err_i = 1'b0;
    i_cap = '0; i_req = 1'b0; i_addr = 32'h0;
    i_gnt_i = 1'b0; i_rvalid_i = 1'b0; i_err_i = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_rvalid", 32'(d_rvalid_o), 32'd0);
    chk("rst_err", 32'(d_err_o), 32'd0);
    chk("rst_exc", 32'(d_exc_o), 32'd0);
    chk("rst_upper", 32'(i_upper_o), 32'd0);
    chk("rst_req_o", 32'(d_req_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1; d_gnt_i = 1'b1; i_gnt_i = 1'b1;

    // Load word at 0x1FFC: last in-bounds word, no fault.
    @(negedge clk_i);
    drive(1'b1, good, 32'h1FFC, 1'b0, 2'b00, 4'hF);
    #1;
    chk("t1_req_o", 32'(d_req_o), 32'd1);
    chk("t1_gnt_o", 32'(d_gnt_o), 32'd1);
    @(negedge clk_i);
    drive(1'b0, good, 32'h1FFC, 1'b0, 2'b00, 4'hF);
    d_rvalid_i = 1'b1;
    #1;
    chk("t1_rvalid", 32'(d_rvalid_o), 32'd1);
    chk("t1_err", 32'(d_err_o), 32'd0);
    chk("t1_exc", 32'(d_exc_o), 32'd0);
    @(negedge clk_i);
    d_rvalid_i = 1'b0;
    #1;
    chk("t1_idle", 32'(d_rvalid_o), 32'd0);

    // Word with be=1100 at 0x1FFC: start 0x1FFE, end 0x2002 > top.
    @(negedge clk_i);
    drive(1'b1, good, 32'h1FFC, 1'b0, 2'b00, 4'b1100);
    #1;
    chk("t2_req_o", 32'(d_req_o), 32'd0);
    chk("t2_gnt_o", 32'(d_gnt_o), 32'd1);
    @(negedge clk_i);
    d_req = 1'b0;
    #1;
    chk("t2_rvalid", 32'(d_rvalid_o), 32'd1);
    chk("t2_err", 32'(d_err_o), 32'd1);
    chk("t2_exc", 32'(d_exc_o), 32'h20);
    @(negedge clk_i);
    #1;
    chk("t2_after", 32'(d_rvalid_o), 32'd0);
    chk("t2_exc_hold", 32'(d_exc_o), 32'h20);

    // Untagged, sealed, no load permission, below base: TAG|SEAL|LOAD|LENGTH.
    @(negedge clk_i);
    drive(1'b1, bad, 32'h0FFC, 1'b0, 2'b00, 4'hF);
    #1;
    chk("t2b_gnt_o", 32'(d_gnt_o), 32'd1);
    @(negedge clk_i);
    d_req = 1'b0;
    #1;
    chk("t2b_exc", 32'(d_exc_o), 32'h2B);

    // Exact-fit double and byte accesses at the top, held off by the bus.
    @(negedge clk_i);
    d_gnt_i = 1'b0;
    drive(1'b1, good, 32'h1FF8, 1'b0, 2'b11, 4'hF);
    #1;
    chk("t2c_dbl_req_o", 32'(d_req_o), 32'd1);
    chk("t2c_dbl_gnt_o", 32'(d_gnt_o), 32'd0);
    @(negedge clk_i);
    drive(1'b1, good, 32'h1FFC, 1'b0, 2'b10, 4'b1000);
    #1;
    chk("t2c_byte_req_o", 32'(d_req_o), 32'd1);
    // Double at 0x1FFC overruns by 4 bytes.
    @(negedge clk_i);
    d_gnt_i = 1'b1;
    drive(1'b1, good, 32'h1FFC, 1'b0, 2'b11, 4'hF);
    #1;
    chk("t2c_ovr_req_o", 32'(d_req_o), 32'd0);
    @(negedge clk_i);
    d_req = 1'b0;
    #1;
    chk("t2c_ovr_exc", 32'(d_exc_o), 32'h20);

    // Three back-to-back good loads with responses held back.
    @(negedge clk_i);
    drive(1'b1, good, 32'h1000, 1'b0, 2'b00, 4'hF);
    #1;
    chk("t3_gnt1", 32'(d_gnt_o), 32'd1);
    @(negedge clk_i);
    d_addr = 32'h1004;
    #1;
    chk("t3_gnt2", 32'(d_gnt_o), 32'd1);
    @(negedge clk_i);
    d_addr = 32'h1008;
    #1;
    chk("t3_gnt3_full", 32'(d_gnt_o), 32'd0);
    chk("t3_req3_full", 32'(d_req_o), 32'd0);
    @(negedge clk_i);
    d_rvalid_i = 1'b1;
    #1;
    chk("t3_rsp1", 32'(d_rvalid_o), 32'd1);
    chk("t3_gnt3_pop", 32'(d_gnt_o), 32'd0);
    @(negedge clk_i);
    d_rvalid_i = 1'b0;
    #1;
    chk("t3_gnt3_free", 32'(d_gnt_o), 32'd1);
    @(negedge clk_i);
    d_req = 1'b0; d_rvalid_i = 1'b1; d_err_i = 1'b1;
    #1;
    chk("t3_rsp2_err", 32'(d_err_o), 32'd1);
    @(negedge clk_i);
    d_err_i = 1'b0;
    #1;
    chk("t3_rsp3", 32'(d_rvalid_o), 32'd1);
    chk("t3_rsp3_err", 32'(d_err_o), 32'd0);
    @(negedge clk_i);
    d_rvalid_i = 1'b0;
    #1;
    chk("t3_drained", 32'(d_rvalid_o), 32'd0);

    // Good load outstanding, then a store without store permission.
    @(negedge clk_i);
    drive(1'b1, good, 32'h1000, 1'b0, 2'b00, 4'hF);
    @(negedge clk_i);
    drive(1'b1, nostore, 32'h1004, 1'b1, 2'b00, 4'hF);
    #1;
    chk("t4_wait_gnt", 32'(d_gnt_o), 32'd0);
    chk("t4_we_o", 32'(d_we_o), 32'd0);
    @(negedge clk_i);
    d_rvalid_i = 1'b1;
    #1;
    chk("t4_good_rsp", 32'(d_rvalid_o), 32'd1);
    chk("t4_wait_gnt2", 32'(d_gnt_o), 32'd0);
    @(negedge clk_i);
    d_rvalid_i = 1'b0;
    #1;
    chk("t4_store_gnt", 32'(d_gnt_o), 32'd1);
    chk("t4_store_req_o", 32'(d_req_o), 32'd0);
    @(negedge clk_i);
    drive(1'b0, good, 32'h0, 1'b0, 2'b00, 4'hF);
    #1;
    chk("t4_store_err", 32'(d_err_o), 32'd1);
    chk("t4_store_exc", 32'(d_exc_o), 32'h10);

    // Instruction port: in-bounds halfword, upper half past top.
    @(negedge clk_i);
    i_req = 1'b1; i_cap = i_good; i_addr = 32'h1000;
    #1;
    chk("t5_req_o", 32'(i_req_o), 32'd1);
    chk("t5_gnt_o", 32'(i_gnt_o), 32'd1);
    @(negedge clk_i);
    i_req = 1'b0; i_rvalid_i = 1'b1;
    #1;
    chk("t5_rvalid", 32'(i_rvalid_o), 32'd1);
    chk("t5_err", 32'(i_err_o), 32'd0);
    chk("t5_exc", 32'(i_exc_o), 32'd0);
    chk("t5_upper", 32'(i_upper_o), 32'd1);
    @(negedge clk_i);
    i_rvalid_i = 1'b0;
    #1;
    chk("t5_upper_hold", 32'(i_upper_o), 32'd1);
    // Fetch without execute permission.
    @(negedge clk_i);
    i_req = 1'b1; i_cap = i_noexec; i_addr = 32'h1000;
    #1;
    chk("t5x_req_o", 32'(i_req_o), 32'd0);
    @(negedge clk_i);
    i_req = 1'b0;
    #1;
    chk("t5x_exc", 32'(i_exc_o), 32'h04);
    chk("t5x_upper", 32'(i_upper_o), 32'd0);

    // Reset with two entries outstanding.
    @(negedge clk_i);
    drive(1'b1, good, 32'h1000, 1'b0, 2'b00, 4'hF);
    @(negedge clk_i);
    d_addr = 32'h1004;
    @(negedge clk_i);
    d_req = 1'b0; rst_ni = 1'b0;
    #1;
    chk("t6_rst_rvalid", 32'(d_rvalid_o), 32'd0);
    chk("t6_rst_exc", 32'(d_exc_o), 32'd0);
    chk("t6_rst_err", 32'(d_err_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("t6_post_rvalid", 32'(d_rvalid_o), 32'd0);
    // A faulting request is granted only with an empty FIFO.
    @(negedge clk_i);
    drive(1'b1, good, 32'h1FFC, 1'b0, 2'b00, 4'b1100);
    #1;
    chk("t6_empty_gnt", 32'(d_gnt_o), 32'd1);
    @(negedge clk_i);
    d_req = 1'b0;
    #1;
    chk("t6_fault_exc", 32'(d_exc_o), 32'h20);
    @(negedge clk_i);
    drive(1'b1, good, 32'h1000, 1'b0, 2'b00, 4'hF);
    #1;
    chk("t6_next_req_o", 32'(d_req_o), 32'd1);
    chk("t6_next_gnt_o", 32'(d_gnt_o), 32'd1);
    @(negedge clk_i);
    d_req = 1'b0; d_rvalid_i = 1'b1;
    #1;
    chk("t6_next_rvalid", 32'(d_rvalid_o), 32'd1);
    chk("t6_next_exc", 32'(d_exc_o), 32'd0);
    @(negedge clk_i);
    d_rvalid_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
